ahb_slave_pipe_cntrlr: RTL and testbench

AHB_SLAVE_PIPE_CNTRLR -- requirements
Module: ahb_slave_pipe_cntrlr

---
 rtl/ahb_slave_pkg.sv | 21 ++
 rtl/ahb_addr_check.sv | 20 ++
 rtl/ahb_slave_pipe_cntrlr.sv | 119 +++++++++++
 tb/tb_ahb_slave_pipe_cntrlr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_pkg.sv
// rtl/ahb_slave_pkg.sv - AHB slave pipe controller encodings and FSM state type
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_addr_check.sv
// rtl/ahb_addr_check.sv - combinational address range and size alignment check
module ahb_addr_check
    import ahb_slave_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 16'h00FF
) (
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hsize,
    output logic              err
);

    always_comb begin
        err = (haddr > ADDR_LIMIT)
           || (hsize > HSIZE_WORD)
           || ((hsize == HSIZE_HALF) && haddr[0])
           || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    end

endmodule

// File: rtl/ahb_slave_pipe_cntrlr.sv
// rtl/ahb_slave_pipe_cntrlr.sv - pipelined AHB slave front end driving register-file strobes
module ahb_slave_pipe_cntrlr
    import ahb_slave_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 16'h00FF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [1:0]        reg_size,
    output logic [3:0]        beat_cnt
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        beat_q, beat_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              hreadyout_q, hresp_q, wr_en_q, rd_en_q;
    logic              addr_err;
    logic              accept;

    ahb_addr_check #(
        .ADDR_W     (ADDR_W),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_addr_check (
        .haddr (haddr),
        .hsize (hsize),
        .err   (addr_err)
    );

    // Only states that present hreadyout=1 can overlap a new address phase.
    assign accept = hsel && hready && htrans[1]
                 && ((state_q == ST_IDLE) || (state_q == ST_ACCESS) || (state_q == ST_ERR2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_ACCESS;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'(WAIT_CYCLES - 1);
                end else begin
                    state_d = ST_ACCESS;
                end
            end
        endcase
    end

    always_comb begin
        beat_d  = beat_q;
        write_d = write_q;
        if (accept) begin
            write_d = hwrite;
            if (htrans == HTRANS_NONSEQ) beat_d = 4'd0;
            else if (beat_q != 4'hF)     beat_d = beat_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            beat_q      <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            write_q <= write_d;
            if (accept) begin
                addr_q <= haddr;
                size_q <= hsize[1:0];
            end
            hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            wr_en_q     <= (state_d == ST_ACCESS) && write_d;
            rd_en_q     <= (state_d == ST_ACCESS) && !write_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign reg_addr  = addr_q;
    assign reg_size  = size_q;
    assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_ahb_slave_pipe_cntrlr.sv
// tb/tb_ahb_slave_pipe_cntrlr.sv - scoreboard bench for ahb_slave_pipe_cntrlr at 0 and 3 wait states
module tb_ahb_slave_pipe_cntrlr;

    typedef struct {
        int          dut;
        bit          err;
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [3:0]  beat;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        hsel[2];
    logic [15:0] haddr[2];
    logic [1:0]  htrans[2];
    logic        hwrite[2];
    logic [2:0]  hsize[2];
    logic        hready[2];
    logic        hreadyout[2];
    logic        hresp[2];
    logic        wr_en[2];
    logic        rd_en[2];
    logic [15:0] reg_addr[2];
    logic [1:0]  reg_size[2];
    logic [3:0]  beat_cnt[2];

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   beat_m[2];
    int   waitcnt[2];
    bit   err2_pend[2];
    int   waits[2];

    always #5 clk = ~clk;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb_slave_pipe_cntrlr #(.ADDR_W(16), .WAIT_CYCLES(0), .ADDR_LIMIT(16'h00FF)) dut0 (
        .clk(clk), .n_rst(n_rst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hready(hready[0]), .hreadyout(hreadyout[0]),
        .hresp(hresp[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .reg_addr(reg_addr[0]),
        .reg_size(reg_size[0]), .beat_cnt(beat_cnt[0])
    );

    ahb_slave_pipe_cntrlr #(.ADDR_W(16), .WAIT_CYCLES(3), .ADDR_LIMIT(16'h00FF)) dut1 (
        .clk(clk), .n_rst(n_rst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hready(hready[1]), .hreadyout(hreadyout[1]),
        .hresp(hresp[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .reg_addr(reg_addr[1]),
        .reg_size(reg_size[1]), .beat_cnt(beat_cnt[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference rule: range limit, legal sizes, natural alignment.
    function automatic bit model_err(input int addr, input int size);
        if (addr > 255) return 1'b1;
        if (size > 2) return 1'b1;
        return (addr % (1 << size)) != 0;
    endfunction

    // Called and returns on a falling edge; holds the address phase until accepted.
    task automatic issue(input int d, input bit sel, input logic [1:0] tr, input bit wr,
                         input logic [15:0] addr, input logic [2:0] size);
        bit rdy;
        int n;
        exp_t e;
        hsel[d]   = sel;
        htrans[d] = tr;
        hwrite[d] = wr;
        haddr[d]  = addr;
        hsize[d]  = size;
        n = 0;
        forever begin
            rdy = hready[d];
            @(posedge clk);
            if (rdy || !(sel && tr[1])) break;
            @(negedge clk);
            n++;
            if (n == 20) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: dut %0d never ready", d);
                break;
            end
        end
        if (sel && tr[1] && rdy) begin
            beat_m[d] = (tr == 2'b10) ? 0 : ((beat_m[d] >= 15) ? 15 : beat_m[d] + 1);
            e.dut  = d;
            e.err  = model_err(int'(addr), int'(size));
            e.wr   = wr;
            e.addr = addr;
            e.size = size[1:0];
            e.beat = 4'(beat_m[d]);
            exp_q.push_back(e);
        end
        @(negedge clk);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    task automatic idle(input int d, input int cycles);
        for (int i = 0; i < cycles; i++) issue(d, 1'b0, 2'b00, 1'b0, 16'h0, 3'd0);
    endtask

    task automatic random_run(input int d, input int count);
        logic [15:0] a;
        logic [2:0]  s;
        logic [1:0]  t;
        for (int i = 0; i < count; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a = 16'($urandom_range(0, 16'h013F));
            if ($urandom_range(0, 3) != 0 && s <= 3'd2) a = a & ~16'((1 << s) - 1);
            t = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            issue(d, $urandom_range(0, 5) != 0, t, 1'($urandom_range(0, 1)), a, s);
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        chk({tag, "_hreadyout"}, 32'(hreadyout[d]), 32'd1);
        chk({tag, "_hresp"},     32'(hresp[d]),     32'd0);
        chk({tag, "_strobes"},   {30'd0, wr_en[d], rd_en[d]}, 32'd0);
        chk({tag, "_reg_addr"},  32'(reg_addr[d]),  32'd0);
        chk({tag, "_reg_size"},  32'(reg_size[d]),  32'd0);
        chk({tag, "_beat_cnt"},  32'(beat_cnt[d]),  32'd0);
    endtask

    // Monitor: pops the scoreboard whenever a DUT shows a strobe or an error response.
    initial begin
        exp_t e;
        bit   p;
        waits[0] = 0;
        waits[1] = 3;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (n_rst !== 1'b1) begin
                    waitcnt[d]   = 0;
                    err2_pend[d] = 1'b0;
                    continue;
                end
                p = err2_pend[d];
                err2_pend[d] = 1'b0;
                if (wr_en[d] && rd_en[d]) begin
                    errors++;
                    checks++;
                    $display("FAIL both_strobes: dut %0d wr_en=1 rd_en=1 required one", d);
                end
                if (wr_en[d] || rd_en[d]) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_strobe: dut %0d wr=%0b rd=%0b required none", d, wr_en[d], rd_en[d]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_dut", 32'(d), 32'(e.dut));
                        chk("strobe_on_error", 32'd0, 32'(e.err));
                        chk("strobe_dir", {30'd0, wr_en[d], rd_en[d]}, e.wr ? 32'd2 : 32'd1);
                        chk("reg_addr", 32'(reg_addr[d]), 32'(e.addr));
                        chk("reg_size", 32'(reg_size[d]), 32'(e.size));
                        chk("beat_cnt", 32'(beat_cnt[d]), 32'(e.beat));
                        chk("wait_states", 32'(waitcnt[d]), 32'(waits[d]));
                        chk("access_ready_resp", {30'd0, hreadyout[d], hresp[d]}, 32'd2);
                    end
                    waitcnt[d] = 0;
                end else if (!hreadyout[d] && !hresp[d]) begin
                    waitcnt[d]++;
                end else if (!hreadyout[d] && hresp[d]) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_error: dut %0d hresp=1 required no transfer", d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("error_dut", 32'(d), 32'(e.dut));
                        chk("error_expected", 32'(e.err), 32'd1);
                        chk("error_no_wait", 32'(waitcnt[d]), 32'd0);
                    end
                    err2_pend[d] = 1'b1;
                    waitcnt[d]   = 0;
                end else if (hreadyout[d] && hresp[d]) begin
                    chk("err2_after_err1", 32'(p), 32'd1);
                    waitcnt[d] = 0;
                end else begin
                    waitcnt[d] = 0;
                end
                if (p && !(hreadyout[d] && hresp[d])) begin
                    errors++;
                    checks++;
                    $display("FAIL err2_missing: dut %0d hreadyout=%0b hresp=%0b required 1,1", d, hreadyout[d], hresp[d]);
                end
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 16'h0; htrans[d] = 2'b00;
            hwrite[d] = 1'b0; hsize[d] = 3'd0; beat_m[d] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        n_rst = 1'b1;
        @(negedge clk);

        // Zero wait states: single write, burst with BUSY, error cases.
        issue(0, 1'b1, 2'b10, 1'b1, 16'h0010, 3'd2);
        idle(0, 2);
        issue(0, 1'b1, 2'b10, 1'b1, 16'h0020, 3'd2);
        issue(0, 1'b1, 2'b11, 1'b1, 16'h0024, 3'd2);
        issue(0, 1'b1, 2'b01, 1'b1, 16'h0028, 3'd2);
        issue(0, 1'b1, 2'b11, 1'b1, 16'h0028, 3'd2);
        issue(0, 1'b1, 2'b11, 1'b1, 16'h002C, 3'd2);
        idle(0, 2);
        issue(0, 1'b1, 2'b10, 1'b0, 16'h0100, 3'd0);
        idle(0, 3);
        issue(0, 1'b1, 2'b10, 1'b0, 16'h0003, 3'd1);
        issue(0, 1'b1, 2'b10, 1'b0, 16'h0000, 3'd3);
        issue(0, 1'b1, 2'b10, 1'b0, 16'h00FF, 3'd0);
        idle(0, 3);
        random_run(0, 150);
        idle(0, 6);

        // Three wait states: read, errors, reset mid-WAIT, then random traffic.
        issue(1, 1'b1, 2'b10, 1'b0, 16'h0004, 3'd2);
        idle(1, 6);
        issue(1, 1'b1, 2'b10, 1'b0, 16'h0100, 3'd2);
        issue(1, 1'b1, 2'b10, 1'b1, 16'h0008, 3'd0);
        idle(1, 6);
        issue(1, 1'b1, 2'b10, 1'b1, 16'h0040, 3'd2);
        issue(1, 1'b1, 2'b11, 1'b1, 16'h0044, 3'd2);
        idle(1, 6);
        issue(1, 1'b1, 2'b10, 1'b0, 16'h0004, 3'd2);
        #1 n_rst = 1'b0;
        #1 check_reset_outputs(1, "midwait_reset");
        exp_q.delete();
        beat_m[0] = 0;
        beat_m[1] = 0;
        @(negedge clk);
        n_rst = 1'b1;
        idle(1, 8);
        random_run(1, 120);
        idle(1, 10);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
